// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the default datapath width.
package md_pkg;

  localparam int MD_DATA_W = 32;

  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Unsigned iterative restoring divider, one quotient bit per cycle.
// ready_o is high when the core will hold a final result after the current edge.
module md_div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              cancel_i,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic              ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // The quotient register doubles as the dividend shift register.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    count_d = count_q;
    shifted = {rem_q, quo_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (cancel_i) begin
      count_d = '0;
    end else if (start_i) begin
      rem_d   = '0;
      quo_d   = dividend_i;
      dvs_d   = divisor_i;
      count_d = CNT_W'(DATA_W);
    end else if (count_q != '0) begin
      rem_d   = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
      quo_d   = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      count_q <= '0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      count_q <= count_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign ready_o     = (count_q <= CNT_W'(1));

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers, valid/ready request and done pulse.
// Define MD_DIV_EARLY_TERM_EN to skip the iterations when |dividend| < |divisor|.
import md_pkg::*;

module md_unit #(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic              cancel_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  md_state_e state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] opA_q, opA_d, opB_q, opB_d;
  logic opSigned_q, opSigned_d, early_q, early_d, done_q, done_d;

  logic accept, reqSigned, isDivReq, earlyTerm, divStart, divReady, s1, s2;
  logic [DATA_W-1:0] absA, absB, divQuo, divRem, quoFix, remFix;
  logic [2*DATA_W-1:0] mulA, mulB, product;

  assign accept    = req_valid_i && req_ready_o;
  assign reqSigned = (req_op_i == MD_OP_MULT) || (req_op_i == MD_OP_DIV);
  assign isDivReq  = (req_op_i == MD_OP_DIV) || (req_op_i == MD_OP_DIVU);
  assign absA      = (reqSigned && src1_i[DATA_W-1]) ? -src1_i : src1_i;
  assign absB      = (reqSigned && src2_i[DATA_W-1]) ? -src2_i : src2_i;

`ifdef MD_DIV_EARLY_TERM_EN
  assign earlyTerm = (src2_i != '0) && (absA < absB);
`else
  assign earlyTerm = 1'b0;
`endif

  assign divStart = accept && isDivReq && !earlyTerm;

  md_div_core #(.DATA_W(DATA_W)) u_div (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (divStart),
    .dividend_i  (absA),
    .divisor_i   (absB),
    .cancel_i    (cancel_i),
    .quotient_o  (divQuo),
    .remainder_o (divRem),
    .ready_o     (divReady)
  );

  // Sign-extending to 2*DATA_W lets one multiplier serve MULT and MULTU.
  assign mulA    = {{DATA_W{opSigned_q & opA_q[DATA_W-1]}}, opA_q};
  assign mulB    = {{DATA_W{opSigned_q & opB_q[DATA_W-1]}}, opB_q};
  assign product = mulA * mulB;

  assign s1     = opSigned_q & opA_q[DATA_W-1];
  assign s2     = opSigned_q & opB_q[DATA_W-1];
  assign quoFix = (s1 ^ s2) ? -divQuo : divQuo;
  assign remFix = s1 ? -divRem : divRem;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    opSigned_d = opSigned_q;
    early_d    = early_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opA_d      = src1_i;
          opB_d      = src2_i;
          opSigned_d = reqSigned;
          early_d    = earlyTerm;
          case (req_op_i)
            MD_OP_MTHI: begin hi_d = src1_i; done_d = 1'b1; end
            MD_OP_MTLO: begin lo_d = src1_i; done_d = 1'b1; end
            MD_OP_MULT, MD_OP_MULTU: state_d = MUL;
            MD_OP_DIV, MD_OP_DIVU:   state_d = earlyTerm ? FIX : DIV;
            default: ;
          endcase
        end
      end
      MUL: begin
        state_d = IDLE;
        if (!cancel_i) begin
          {hi_d, lo_d} = product;
          done_d       = 1'b1;
        end
      end
      DIV: begin
        if (cancel_i)      state_d = IDLE;
        else if (divReady) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel_i) begin
          done_d = 1'b1;
          // Divide by zero reports the raw dividend, bypassing sign correction.
          if (opB_q == '0) begin
            lo_d = '1;
            hi_d = opA_q;
          end else if (early_q) begin
            lo_d = '0;
            hi_d = opA_q;
          end else begin
            lo_d = quoFix;
            hi_d = remFix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      opSigned_q <= 1'b0;
      early_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      opSigned_q <= opSigned_d;
      early_q    <= early_d;
      done_q     <= done_d;
    end
  end

  assign req_ready_o = (state_q == IDLE) && !cancel_i;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: requests push expected HI/LO and done cycle,
// a monitor pops and compares on every done pulse.
module tb_md_unit;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   req_op = 3'd0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         req_ready, busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           doneCyc;
  } exp_t;

  exp_t sbQ[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  md_unit dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .src1_i      (src1),
    .src2_i      (src2),
    .cancel_i    (cancel),
    .busy_o      (busy),
    .done_o      (done),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request; returns the cycle number of the accepting edge.
  task automatic applyStimulus(input string name, input logic [2:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit expectDone, input logic [W-1:0] expHi,
                               input logic [W-1:0] expLo, input int lat,
                               output int accCyc);
    bit got = 1'b0;
    req_op    = op;
    src1      = a;
    src2      = b;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_ready_timeout: got ready=0 expected ready=1", name);
      req_valid = 1'b0;
      accCyc    = -1;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    accCyc    = cyc;
    if (expectDone) sbQ.push_back('{name, expHi, expLo, cyc + lat - 1});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected done=0 (hi=0x%0h lo=0x%0h)", hi, lo);
      end else begin
        e = sbQ.pop_front();
        checkOutput({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        checkOutput({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        checkOutput({e.name, "_cycle"}, 64'(cyc), 64'(e.doneCyc));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, acc2, abortCyc;
    #2;
    checkOutput("reset_hi", 64'(hi), 0);
    checkOutput("reset_lo", 64'(lo), 0);
    checkOutput("reset_busy", 64'(busy), 0);
    checkOutput("reset_done", 64'(done), 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 checkOutput("ready_after_reset", 64'(req_ready), 1);

    applyStimulus("mthi", MD_OP_MTHI, 32'h11111111, 32'h0, 1, 32'h11111111, 32'h0, 1, acc);
    applyStimulus("mtlo", MD_OP_MTLO, 32'h22222222, 32'h0, 1, 32'h11111111, 32'h22222222, 1, acc);
    applyStimulus("mult", MD_OP_MULT, 32'hFFFFFFFF, 32'h2, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, acc);
    applyStimulus("multu", MD_OP_MULTU, 32'hFFFFFFFF, 32'h2, 1, 32'h00000001, 32'hFFFFFFFE, 2, acc);
    applyStimulus("div_m7_2", MD_OP_DIV, 32'hFFFFFFF9, 32'h2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, acc);
    applyStimulus("div_7_m2", MD_OP_DIV, 32'h7, 32'hFFFFFFFE, 1, 32'h1, 32'hFFFFFFFD, 34, acc);
    applyStimulus("divu_by0", MD_OP_DIVU, 32'd100, 32'h0, 1, 32'd100, 32'hFFFFFFFF, 34, acc);
    applyStimulus("div_m5_by0", MD_OP_DIV, 32'hFFFFFFFB, 32'h0, 1, 32'hFFFFFFFB, 32'hFFFFFFFF, 34, acc);
    applyStimulus("div_ovf", MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 34, acc);
    applyStimulus("divu_100_7", MD_OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 34, acc);
    applyStimulus("divu_big", MD_OP_DIVU, 32'hFFFFFFFF, 32'h10, 1, 32'hF, 32'h0FFFFFFF, 34, acc);

    applyStimulus("rsvd", 3'd6, 32'hFFFF, 32'hFFFF, 0, 32'h0, 32'h0, 0, acc);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rsvd_busy", 64'(busy), 0);
    checkOutput("rsvd_hi", 64'(hi), 64'h0000000F);
    checkOutput("rsvd_lo", 64'(lo), 64'h0FFFFFFF);

    @(negedge clk);
    req_valid = 1'b1;
    req_op    = MD_OP_MTHI;
    src1      = 32'hDEAD;
    cancel    = 1'b1;
    #1 checkOutput("cancel_blocks_ready", 64'(req_ready), 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cancel    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("cancel_req_hi", 64'(hi), 64'h0000000F);
    checkOutput("cancel_req_busy", 64'(busy), 0);

    applyStimulus("divu_cancel", MD_OP_DIVU, 32'd50, 32'd7, 0, 32'h0, 32'h0, 0, acc);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("div_busy_before_cancel", 64'(busy), 1);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel   = 1'b0;
    abortCyc = cyc;
    checkOutput("cancel_busy", 64'(busy), 0);
    checkOutput("cancel_hi_kept", 64'(hi), 64'h0000000F);
    checkOutput("cancel_lo_kept", 64'(lo), 64'h0FFFFFFF);
    applyStimulus("mtlo_after_cancel", MD_OP_MTLO, 32'h1234, 32'h0, 1, 32'hF, 32'h1234, 1, acc);
    checkOutput("mtlo_accept_cycle", 64'(acc), 64'(abortCyc + 1));

    applyStimulus("mthi_b2b", MD_OP_MTHI, 32'hA, 32'h0, 1, 32'hA, 32'h1234, 1, acc);
    applyStimulus("multu_b2b", MD_OP_MULTU, 32'd3, 32'd5, 1, 32'h0, 32'd15, 2, acc2);
    checkOutput("b2b_accept_cycle", 64'(acc2), 64'(acc + 1));

    applyStimulus("mthi_pre_reset", MD_OP_MTHI, 32'h5A5A, 32'h0, 1, 32'h5A5A, 32'd15, 1, acc);
    applyStimulus("div_reset", MD_OP_DIV, 32'd1000, 32'd3, 0, 32'h0, 32'h0, 0, acc);
    repeat (5) @(posedge clk);
    #1 checkOutput("div_running", 64'(busy), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", 64'(busy), 0);
    checkOutput("async_reset_hi", 64'(hi), 0);
    checkOutput("async_reset_lo", 64'(lo), 0);
    checkOutput("async_reset_done", 64'(done), 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 checkOutput("ready_after_reset2", 64'(req_ready), 1);

    repeat (3) @(posedge clk);
    #1 checkOutput("scoreboard_empty", 64'(sbQ.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers for the execute stage.
- Replaces the vendor divider IP and the inline multiplier.
- Iterative radix-2 divider, registered multiplier, MTHI/MTLO writes.
- valid/ready request handshake, done pulse, and a cancel input driven by pipeline flush.

Parameters:
- DATA_W, 32: operand, HI and LO width (even, >= 8).
- CNT_W, $clog2(DATA_W)+1: divider iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved.
- src1  in  DATA_W  rs value; dividend / multiplicand / MTHI-MTLO data.
- src2  in  DATA_W  rt value; divisor / multiplier.
- cancel  in  1  flush; aborts the in-flight op and drops a same-cycle request.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, coincides with the cycle HI/LO first show the new result.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:
- Reset (async): state=IDLE; hi=0, lo=0, done=0, busy=0. req_ready=1 once reset deasserts.
- req_ready = (state==IDLE) && !cancel.
- Accept = req_valid && req_ready. Reserved op codes: accepted, no effect, no done.
- States: IDLE, MUL, DIV, FIX.
- MTHI/MTLO: on accept, hi (or lo) <= src1 at the next edge. done pulses the following cycle; the other register is unchanged; state stays IDLE.
- MULT/MULTU: operands latched on accept, state->MUL.
  - In MUL: {hi,lo} <= product (signed for MULT, unsigned for MULTU, 2*DATA_W bits), state->IDLE.
  - done asserted the cycle after the write. Accept-to-done = 2 cycles.
- DIV/DIVU, accept: latch |src1| and |src2| (signed mode) or raw values, the sign flags, and count=DATA_W; state->DIV.
  - Each DIV cycle: one restoring step (shift remainder left, trial subtract, set quotient bit), count-1. When count reaches 0, state->FIX.
  - FIX: apply signs. Quotient is negated iff s1^s2; remainder is negated iff s1. Write lo=quotient, hi=remainder, state->IDLE.
  - done pulses the next cycle. Accept-to-done = DATA_W+2 cycles (34 at default).
- Divide by zero: no exception. lo = all ones, hi = src1, for both DIV and DIVU; FIX sign correction is bypassed.
- Signed overflow (src1 = most-negative value, src2 = -1): lo = most-negative value, hi = 0 (natural wrap).
- cancel in MUL/DIV/FIX: state->IDLE next edge, hi/lo unchanged, no done.
- cancel in the accept cycle: request not taken (req_ready=0).
- cancel in IDLE with nothing in flight: no effect.
- A done pulse and a new accept may occur in the same cycle. Back-to-back ops are therefore legal: the new op sees the updated hi/lo.
- Reset asserted mid-division: immediate return to IDLE, hi/lo cleared.

Optional Feature:
- Macro MD_DIV_EARLY_TERM_EN.
- Defined: on a DIV/DIVU accept with nonzero divisor and |src1| < |src2|, skip DIV and go straight to FIX with quotient=0, remainder=src1 (sign rules unchanged). Accept-to-done = 2 cycles for these cases.
- Undefined: every division takes DATA_W+2 cycles.
- Results are identical either way.

Decomposition:
- Package md_pkg: op encoding constants (MD_OP_MULT ... MD_OP_MTLO), state enum (IDLE, MUL, DIV, FIX), and a default DATA_W constant.
- Sub-module md_div_core: unsigned iterative restoring divider.
  - Inputs: start, dividend, divisor, cancel.
  - Outputs: quotient, remainder, ready.
- md_unit owns sign handling, the multiplier, HI/LO and the handshake.

Test Plan:
- DIV src1=-7 (0xFFFFFFF9), src2=2 -> done at cycle 34 after accept; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU src1=100, src2=0 -> lo=0xFFFFFFFF, hi=100.
- DIV src1=0x80000000, src2=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT src1=0xFFFFFFFF, src2=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 2 cycles after accept.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIVU 50/7 with cancel at cycle 10 -> no done, hi/lo keep their prior values. A following MTLO 0x1234 is accepted the cycle after the abort and gives lo=0x1234.
- Back-to-back MTHI 0xA then MULTU src1=3, src2=5 issued the cycle done pulses -> hi=0, lo=15. Async reset asserted mid-DIV -> busy=0, hi=lo=0 with no clock edge.
